// File: rtl/axi_wr_sink_mem.sv
// AXI3-style write-only slave storing beats in a small register-array memory,
// with a 1-cycle local read port. Optional wid/awid checking via AXI_SINK_ID_CHECK_EN.
module axi_wr_sink_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [3:0]                   awid_i,
  input  logic [3:0]                   awlen_i,
  input  logic [2:0]                   awsize_i,
  input  logic [1:0]                   awburst_i,
  input  logic [ADDR_WIDTH-1:0]        awaddr_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [3:0]                   wid_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [3:0]                   wstrb_i,
  input  logic                         wlast_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [3:0]                   bid_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic [15:0]                  wr_count_o
);

  localparam int unsigned IW = $clog2(MEM_DEPTH);
  // Running index is wider than IW so an INCR burst running past the end stays detectable.
  localparam int unsigned XW = 9;
  localparam logic [XW-1:0] DEPTH_X = XW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [3:0]            strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_w[8*k +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [XW-1:0] wrap_next(input logic [XW-1:0] idx, input logic [3:0] len);
    logic [XW-1:0] mask;
    mask = XW'(len);
    return (idx & ~mask) | ((idx + XW'(1)) & mask);
  endfunction

  state_e                 state_q, state_d;
  logic [3:0]             id_q, id_d;
  logic [3:0]             len_q, len_d;
  logic [1:0]             burst_q, burst_d;
  logic [XW-1:0]          idx_q, idx_d;
  logic [3:0]             beat_q, beat_d;
  logic                   err_q, err_d;
  logic                   supp_q, supp_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [3:0]             bid_q, bid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [15:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0]  addr_off_s;
  logic [ADDR_WIDTH-1:0]  word_s;
  logic                   aw_err_s;
  logic                   id_ok_s;
  logic                   in_range_s;
  logic                   last_s;
  logic                   we_s;
  logic                   unused_s;

  assign addr_off_s = awaddr_i - BASE_ADDR;
  assign word_s     = addr_off_s >> 2;
  assign aw_err_s   = (awsize_i != 3'd2)
                   || (awaddr_i < BASE_ADDR)
                   || (word_s >= ADDR_WIDTH'(MEM_DEPTH))
                   || ((awburst_i == 2'b10) && !(awlen_i inside {4'd1, 4'd3, 4'd7, 4'd15}));
  assign in_range_s = (idx_q < DEPTH_X);
  assign last_s     = (beat_q == len_q);

`ifdef AXI_SINK_ID_CHECK_EN
  assign id_ok_s  = (wid_i == id_q);
  assign unused_s = 1'b0;
`else
  assign id_ok_s  = 1'b1;
  assign unused_s = ^wid_i;
`endif

  // Next-state, burst bookkeeping and registered-output decode.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    burst_d   = burst_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    err_d     = err_q;
    supp_d    = supp_q;
    count_d   = count_q;
    we_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (awvalid_i && awready_q) begin
          id_d    = awid_i;
          len_d   = awlen_i;
          burst_d = awburst_i;
          idx_d   = word_s[XW-1:0];
          beat_d  = 4'd0;
          err_d   = aw_err_s;
          supp_d  = aw_err_s;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (wvalid_i && wready_q) begin
          we_s = !supp_q && id_ok_s && in_range_s;
          if (!in_range_s || !id_ok_s || (wlast_i != last_s)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          case (burst_q)
            2'b01:   idx_d = idx_q + XW'(1);
            2'b10:   idx_d = wrap_next(idx_q, len_q);
            default: idx_d = idx_q;
          endcase
          if (last_s) begin
            state_d = ST_RESP;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        if (bvalid_q && bready_i) begin
          state_d = ST_IDLE;
          if (!err_q && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    awready_d = (state_d == ST_IDLE);
    wready_d  = (state_d == ST_DATA);
    bvalid_d  = (state_d == ST_RESP);
    if (state_d == ST_RESP) begin
      bid_d   = id_d;
      bresp_d = err_d ? 2'b10 : 2'b00;
    end else begin
      bid_d   = bid_q;
      bresp_d = bresp_q;
    end
  end

  // Control and handshake registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= ST_IDLE;
      id_q      <= 4'd0;
      len_q     <= 4'd0;
      burst_q   <= 2'b00;
      idx_q     <= '0;
      beat_q    <= 4'd0;
      err_q     <= 1'b0;
      supp_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 4'd0;
      bresp_q   <= 2'b00;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      idx_q     <= idx_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      supp_q    <= supp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      count_q   <= count_d;
    end
  end

  // Storage array; cleared on reset so an aborted burst leaves nothing behind.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_s) begin
      mem_q[idx_q[IW-1:0]] <= merge_bytes(mem_q[idx_q[IW-1:0]], wdata_i, wstrb_i);
    end
  end

  // Local read port, one cycle of latency.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rd_data_q <= '0;
    end else if (32'(rd_addr_i) < MEM_DEPTH) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign awready_o  = awready_q;
  assign wready_o   = wready_q;
  assign bvalid_o   = bvalid_q;
  assign bid_o      = bid_q;
  assign bresp_o    = bresp_q;
  assign rd_data_o  = rd_data_q;
  assign wr_count_o = count_q;

endmodule

// File: tb/tb_axi_wr_sink_mem.sv
// Scoreboard bench for axi_wr_sink_mem: expected B responses and read words are queued
// by the stimulus thread and popped by monitor processes.
module tb_axi_wr_sink_mem;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awid_i;
  logic [3:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic [63:0] awaddr_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [3:0]  wid_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wlast_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [3:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic [15:0] wr_count_o;

  axi_wr_sink_mem dut (
    .clk(clk), .areset(areset),
    .awid_i(awid_i), .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .wr_count_o(wr_count_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          b_done   = 0;
  int          b_target = 0;
  logic        rd_strobe = 1'b0;
  logic [5:0]  b_q [$];
  logic [31:0] rd_q [$];
  logic [31:0] bd [16];
  logic [3:0]  bs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // B channel monitor
  always @(negedge clk) begin
    if (bvalid_o && bready_i) begin
      if (b_q.size() > 0) begin
        logic [5:0] e;
        e = b_q.pop_front();
        check("b_id_resp", {bid_o, bresp_o}, e);
      end else begin
        check("b_unexpected", 64'd1, 64'd0);
      end
      b_done++;
    end
  end

  // Read port monitor
  always @(negedge clk) begin
    if (rd_strobe) begin
      if (rd_q.size() > 0) begin
        logic [31:0] e;
        e = rd_q.pop_front();
        check("rd_data", rd_data_o, e);
      end else begin
        check("rd_unexpected", 64'd1, 64'd0);
      end
    end
  end

  task automatic rd_check(input int idx, input logic [31:0] exp);
    rd_addr_i = 4'(idx);
    @(posedge clk); #1;
    rd_q.push_back(exp);
    rd_strobe = 1'b1;
    @(posedge clk); #1;
    rd_strobe = 1'b0;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] btype, input logic [63:0] addr);
    int   n;
    logic ok;
    n = 0; ok = 1'b0;
    awid_i = id; awlen_i = len; awsize_i = size; awburst_i = btype; awaddr_i = addr;
    awvalid_i = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk); ok = awready_o;
      @(posedge clk); #1; n++;
    end
    awvalid_i = 1'b0;
    check("aw_handshake", ok, 1'b1);
  endtask

  task automatic do_w(input logic [3:0] wid, input logic [31:0] data, input logic [3:0] strb,
                      input logic last);
    int   n;
    logic ok;
    n = 0; ok = 1'b0;
    wid_i = wid; wdata_i = data; wstrb_i = strb; wlast_i = last;
    wvalid_i = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk); ok = wready_o;
      @(posedge clk); #1; n++;
    end
    wvalid_i = 1'b0;
    check("w_handshake", ok, 1'b1);
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (b_done < b_target && n < 50) begin
      @(posedge clk); n++;
    end
    #1;
    check("b_arrived", (b_done >= b_target), 1'b1);
  endtask

  task automatic burst(input logic [3:0] id, input logic [3:0] wid, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] btype, input logic [63:0] addr,
                       input logic [15:0] lastv, input logic [1:0] resp);
    b_q.push_back({id, resp});
    b_target++;
    do_aw(id, len, size, btype, addr);
    for (int b = 0; b <= int'(len); b++) begin
      do_w(wid, bd[b], bs[b], lastv[b]);
    end
    wait_b();
  endtask

  function automatic logic [15:0] lastbit(input int len);
    logic [15:0] one;
    one = 16'h0001;
    return one << len;
  endfunction

  task automatic full_strb();
    for (int i = 0; i < 16; i++) bs[i] = 4'hF;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready_o, 1'b1);
    check({tag, "_wready"}, wready_o, 1'b0);
    check({tag, "_bvalid"}, bvalid_o, 1'b0);
    check({tag, "_bid"}, bid_o, 4'd0);
    check({tag, "_bresp"}, bresp_o, 2'b00);
    check({tag, "_rd_data"}, rd_data_o, 32'd0);
    check({tag, "_wr_count"}, wr_count_o, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b1;
    awid_i = 4'd0; awlen_i = 4'd0; awsize_i = 3'd2; awburst_i = 2'b01; awaddr_i = 64'd0;
    wid_i = 4'd0; wdata_i = 32'd0; wstrb_i = 4'h0; wlast_i = 1'b0; rd_addr_i = 4'd0;
    full_strb();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    areset = 1'b1;
    @(posedge clk); #1;

    // Single INCR write
    bd[0] = 32'hDEADBEEF;
    burst(4'd5, 4'd5, 4'd0, 3'd2, 2'b01, 64'h8, lastbit(0), 2'b00);
    rd_check(2, 32'hDEADBEEF);
    check("count_single", wr_count_o, 16'd1);

    // Prior value for the strobed beat, then INCR burst with partial strobe
    bd[0] = 32'hAABBCCDD;
    burst(4'd1, 4'd1, 4'd0, 3'd2, 2'b01, 64'h8, lastbit(0), 2'b00);
    bd[0] = 32'd1; bd[1] = 32'd2; bd[2] = 32'd3; bd[3] = 32'd4; bs[2] = 4'h3;
    burst(4'd2, 4'd2, 4'd3, 3'd2, 2'b01, 64'h0, lastbit(3), 2'b00);
    full_strb();
    rd_check(0, 32'd1);
    rd_check(1, 32'd2);
    rd_check(2, 32'hAABB0003);
    rd_check(3, 32'd4);
    check("count_incr", wr_count_o, 16'd3);

    // WRAP burst from index 6
    bd[0] = 32'hA; bd[1] = 32'hB; bd[2] = 32'hC; bd[3] = 32'hD;
    burst(4'd3, 4'd3, 4'd3, 3'd2, 2'b10, 64'h18, lastbit(3), 2'b00);
    rd_check(6, 32'hA);
    rd_check(7, 32'hB);
    rd_check(4, 32'hC);
    rd_check(5, 32'hD);
    check("count_wrap", wr_count_o, 16'd4);

    // Out-of-range start address
    bd[0] = 32'h12345678;
    burst(4'd4, 4'd4, 4'd0, 3'd2, 2'b01, 64'h40, lastbit(0), 2'b10);
    rd_check(0, 32'd1);
    check("count_range_err", wr_count_o, 16'd4);

    // Unsupported beat size
    bd[0] = 32'h55555555;
    burst(4'd6, 4'd6, 4'd0, 3'd1, 2'b01, 64'h24, lastbit(0), 2'b10);
    rd_check(9, 32'd0);

    // Early wlast: error response but both beats written
    bd[0] = 32'h11; bd[1] = 32'h22;
    burst(4'd7, 4'd7, 4'd1, 3'd2, 2'b01, 64'h28, 16'h0003, 2'b10);
    rd_check(10, 32'h11);
    rd_check(11, 32'h22);

    // INCR running off the end of memory
    bd[0] = 32'h77; bd[1] = 32'h88;
    burst(4'd8, 4'd8, 4'd1, 3'd2, 2'b01, 64'h3C, lastbit(1), 2'b10);
    rd_check(15, 32'h77);
    rd_check(0, 32'd1);
    check("count_after_errs", wr_count_o, 16'd4);

    // Backpressure on B
    bready_i = 1'b0;
    b_q.push_back({4'd9, 2'b00});
    b_target++;
    do_aw(4'd9, 4'd0, 3'd2, 2'b01, 64'h30);
    do_w(4'd9, 32'hCAFEF00D, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid", bvalid_o, 1'b1);
      check("bp_bid", bid_o, 4'd9);
      check("bp_bresp", bresp_o, 2'b00);
      check("bp_awready", awready_o, 1'b0);
    end
    @(posedge clk); #1;
    bready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_awready_after", awready_o, 1'b1);
    check("bp_bvalid_after", bvalid_o, 1'b0);
    wait_b();
    rd_check(12, 32'hCAFEF00D);
    check("count_bp", wr_count_o, 16'd5);

    // Reset in the middle of a 4-beat burst
    do_aw(4'd1, 4'd3, 3'd2, 2'b01, 64'h0);
    do_w(4'd1, 32'h99, 4'hF, 1'b0);
    do_w(4'd1, 32'h98, 4'hF, 1'b0);
    areset = 1'b0;
    #2;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    areset = 1'b1;
    rd_check(0, 32'd0);
    rd_check(1, 32'd0);
    rd_check(12, 32'd0);
    bd[0] = 32'h0BADCAFE;
    burst(4'hA, 4'hA, 4'd0, 3'd2, 2'b01, 64'h4, lastbit(0), 2'b00);
    rd_check(1, 32'h0BADCAFE);
    check("count_after_rst", wr_count_o, 16'd1);

`ifdef AXI_SINK_ID_CHECK_EN
    bd[0] = 32'h5A5A5A5A;
    burst(4'd3, 4'd5, 4'd0, 3'd2, 2'b01, 64'h38, lastbit(0), 2'b10);
    rd_check(14, 32'd0);
    check("count_id_err", wr_count_o, 16'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("b_queue_empty", 64'(b_q.size()), 64'd0);
    check("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
